usb_blaster_cmd_engine: RTL and testbench
=========================================

Name: usb_blaster_cmd_engine

Overview:
- Consumes host bytes that the FT245 bridge has written into the RX FIFO.
- Executes USB-Blaster protocol commands on the JTAG/AS pins: bit-bang mode and byte-shift mode.
- Pushes read-back bytes into the TX FIFO, which the FT245 bridge drains to the host.
- Sits between the RX/TX FIFOs and the target JTAG chain.

Parameters:
TCK_HALF, 2, TCK half-period in CLK cycles during byte-shift; legal range 1..255.

Ports:
CLK  in  1  system clock (24/25 MHz)
nRST  in  1  reset; synchronous, active-low
RX_EMPTY  in  1  RX FIFO empty flag
RX_RD_REQ  out  1  RX FIFO read strobe; one-cycle pulse
RX_DATA  in  8  RX FIFO output; valid in the cycle after RX_RD_REQ
TX_FULL  in  1  TX FIFO full flag
TX_WR_REQ  out  1  TX FIFO write strobe; one-cycle pulse
TX_DATA  out  8  TX FIFO write data; valid while TX_WR_REQ is high
TCK, TMS, TDI  out  1 each  JTAG outputs (registered)
TDO  in  1  JTAG return (already synchronised upstream)
NCE, NCS  out  1 each  AS-mode nCE / nCS
ASDO  in  1  AS data out from target
LED  out  1  activity LED

Behaviour:
- Reset (nRST low at a CLK edge):
  - State goes to IDLE.
  - TCK=0, TMS=0, TDI=0, NCE=1, NCS=1, LED=0, RX_RD_REQ=0, TX_WR_REQ=0, TX_DATA=0.
  - Shift counters are cleared. Any partially executed command is abandoned; no TX byte is written for it.
- All outputs are registered.
- States: IDLE, FETCH, DECODE, BB_SAMPLE, BB_REPLY, SH_FETCH, SH_LOAD, SH_LOW, SH_HIGH, SH_REPLY.
- IDLE: if RX_EMPTY=0 → FETCH.
- FETCH: RX_RD_REQ=1 for exactly this cycle → DECODE.
- DECODE: latch RX_DATA as cmd.
  - cmd[7]=0, bit-bang, on the next edge: TCK=cmd[0], TMS=cmd[1], NCE=cmd[2], NCS=cmd[3], TDI=cmd[4], LED=cmd[5].
    - cmd[6]=1 → BB_SAMPLE; else → IDLE.
  - cmd[7]=1, byte-shift: cnt=cmd[5:0], rd=cmd[6], TCK forced 0.
    - cnt=0 → IDLE (no-op, no TX write); else → SH_FETCH.
- BB_SAMPLE: capture resp={6'b0, ASDO, TDO}. Sampling happens one cycle after the pin update → BB_REPLY.
- BB_REPLY: wait while TX_FULL=1. When TX_FULL=0: TX_WR_REQ=1 for one cycle with TX_DATA=resp → IDLE.
- SH_FETCH: wait while RX_EMPTY=1. When RX_EMPTY=0: RX_RD_REQ=1 for one cycle → SH_LOAD.
- SH_LOAD: sh=RX_DATA, bit=0, resp=0 → SH_LOW.
- SH_LOW: TDI=sh[bit], TCK=0, held TCK_HALF cycles → SH_HIGH.
- SH_HIGH: TCK=1, held TCK_HALF cycles. resp[bit]=TDO is captured in the first cycle TCK reads high.
  - bit<7: bit+1 → SH_LOW.
  - bit=7: TCK=0; → SH_REPLY if rd=1, else → SH_REPLY is skipped.
- SH_REPLY: same rule as BB_REPLY, with TX_DATA=resp.
- After each shifted byte: cnt decrements; cnt≠0 → SH_FETCH; cnt=0 → IDLE.
- Bit order: LSB first on both TDI and resp.
- During byte-shift, TMS, NCE, NCS and LED hold their last bit-bang values.
- TCK period during shift is 2×TCK_HALF CLK cycles.
- Mid-command stalls:
  - An RX underrun (RX_EMPTY=1) stalls in SH_FETCH with TCK=0, indefinitely.
  - A TX_FULL stall holds all pins static.
- RX_RD_REQ is never asserted while RX_EMPTY=1. TX_WR_REQ is never asserted while TX_FULL=1.
- RX_RD_REQ and TX_WR_REQ are never high in the same cycle.
- Throughput:
  - Bit-bang without read: one command per 3 CLK cycles (IDLE→FETCH→DECODE).
  - Bit-bang with read: 5 cycles with TX_FULL=0.

Test Plan:
- Bit-bang write: RX byte 0x13 → next cycle TCK=1, TMS=1, NCE=0, NCS=0, TDI=1, LED=0; no TX_WR_REQ; one RX_RD_REQ pulse.
- Bit-bang read: RX 0x40 with TDO=1, ASDO=0 → TX_DATA=0x01, exactly one TX_WR_REQ.
  - Repeat with TDO=0, ASDO=1 → TX_DATA=0x02.
- Shift with read, TCK_HALF=2: RX 0xC2, 0xA5, 0x3C with TDO looped to TDI → 16 TCK rising edges, each TCK high for 2 CLK cycles; TDI sequence 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0; TX bytes 0xA5 then 0x3C.
- Shift without read and no-op: RX 0x81, 0xFF → 8 TCK pulses, TDI=1, no TX write. RX 0x80 → no TCK activity, engine back in IDLE after 3 cycles.
- Backpressure/underrun:
  - Hold TX_FULL=1 across a 0x40 command → no TX_WR_REQ, pins static; release → single write.
  - Send 0xC2 then 0x55 only → engine waits in SH_FETCH with TCK=0; supply second byte → completes.
- Reset mid-shift: assert nRST during the 4th bit of a 0xC1 shift → next cycle all outputs at reset values, no TX write. The next command 0x13 executes normally.

Source files
------------

// File: rtl/usb_blaster_cmd_engine.sv
// USB-Blaster command engine: pulls host command bytes from the RX FIFO, drives the
// JTAG/AS pins in bit-bang or byte-shift mode, and pushes read-back bytes to the TX FIFO.
module usb_blaster_cmd_engine #(
    parameter int unsigned TCK_HALF = 2  // TCK half-period in CLK cycles, 1..255
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       RX_EMPTY,
    output logic       RX_RD_REQ,
    input  logic [7:0] RX_DATA,
    input  logic       TX_FULL,
    output logic       TX_WR_REQ,
    output logic [7:0] TX_DATA,
    output logic       TCK,
    output logic       TMS,
    output logic       TDI,
    input  logic       TDO,
    output logic       NCE,
    output logic       NCS,
    input  logic       ASDO,
    output logic       LED
);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StBbSample,
        StBbReply,
        StShFetch,
        StShLoad,
        StShLow,
        StShHigh,
        StShReply
    } state_e;

    localparam logic [7:0] TmrLast = 8'(TCK_HALF - 1);

    state_e     state_q, state_d;
    logic       rx_rd_q, rx_rd_d;
    logic       tx_wr_q, tx_wr_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tck_q, tck_d;
    logic       tms_q, tms_d;
    logic       tdi_q, tdi_d;
    logic       nce_q, nce_d;
    logic       ncs_q, ncs_d;
    logic       led_q, led_d;
    logic       rd_mode_q, rd_mode_d;  // byte-shift command wants read-back
    logic [5:0] cnt_q, cnt_d;          // bytes left in the current byte-shift command
    logic [7:0] sh_q, sh_d;            // byte being shifted out on TDI
    logic [2:0] bit_q, bit_d;
    logic [7:0] tmr_q, tmr_d;          // half-period timer
    logic [7:0] resp_q, resp_d;
    logic [2:0] bit_nxt;

    assign bit_nxt = bit_q + 3'd1;

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= StIdle;
            rx_rd_q   <= 1'b0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            tck_q     <= 1'b0;
            tms_q     <= 1'b0;
            tdi_q     <= 1'b0;
            nce_q     <= 1'b1;
            ncs_q     <= 1'b1;
            led_q     <= 1'b0;
            rd_mode_q <= 1'b0;
            cnt_q     <= 6'd0;
            sh_q      <= 8'h00;
            bit_q     <= 3'd0;
            tmr_q     <= 8'd0;
            resp_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            rx_rd_q   <= rx_rd_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            tck_q     <= tck_d;
            tms_q     <= tms_d;
            tdi_q     <= tdi_d;
            nce_q     <= nce_d;
            ncs_q     <= ncs_d;
            led_q     <= led_d;
            rd_mode_q <= rd_mode_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            tmr_q     <= tmr_d;
            resp_q    <= resp_d;
        end
    end

    // Next-state logic; strobes default low so each is a single-cycle pulse.
    always_comb begin
        state_d   = state_q;
        rx_rd_d   = 1'b0;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        tck_d     = tck_q;
        tms_d     = tms_q;
        tdi_d     = tdi_q;
        nce_d     = nce_q;
        ncs_d     = ncs_q;
        led_d     = led_q;
        rd_mode_d = rd_mode_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        bit_d     = bit_q;
        tmr_d     = tmr_q;
        resp_d    = resp_q;

        unique case (state_q)
            StIdle: begin
                if (!RX_EMPTY) begin
                    rx_rd_d = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (!RX_DATA[7]) begin
                    tck_d   = RX_DATA[0];
                    tms_d   = RX_DATA[1];
                    nce_d   = RX_DATA[2];
                    ncs_d   = RX_DATA[3];
                    tdi_d   = RX_DATA[4];
                    led_d   = RX_DATA[5];
                    state_d = RX_DATA[6] ? StBbSample : StIdle;
                end else begin
                    cnt_d     = RX_DATA[5:0];
                    rd_mode_d = RX_DATA[6];
                    tck_d     = 1'b0;
                    state_d   = (RX_DATA[5:0] == 6'd0) ? StIdle : StShFetch;
                end
            end
            // Pins were updated on entry; sample the target one cycle later.
            StBbSample: begin
                resp_d  = {6'b0, ASDO, TDO};
                state_d = StBbReply;
            end
            StBbReply: begin
                if (!TX_FULL) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = resp_q;
                    state_d   = StIdle;
                end
            end
            // The read strobe is issued from here; its data arrives in StShLoad.
            StShFetch: begin
                if (rx_rd_q) begin
                    state_d = StShLoad;
                end else if (!RX_EMPTY) begin
                    rx_rd_d = 1'b1;
                end
            end
            StShLoad: begin
                sh_d    = RX_DATA;
                bit_d   = 3'd0;
                resp_d  = 8'h00;
                tmr_d   = 8'd0;
                tdi_d   = RX_DATA[0];
                tck_d   = 1'b0;
                state_d = StShLow;
            end
            StShLow: begin
                if (tmr_q == TmrLast) begin
                    tmr_d   = 8'd0;
                    tck_d   = 1'b1;
                    state_d = StShHigh;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            StShHigh: begin
                if (tmr_q == 8'd0) begin
                    resp_d[bit_q] = TDO;
                end
                if (tmr_q == TmrLast) begin
                    tmr_d = 8'd0;
                    tck_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_nxt;
                        tdi_d   = sh_q[bit_nxt];
                        state_d = StShLow;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                        if (rd_mode_q) begin
                            state_d = StShReply;
                        end else begin
                            state_d = (cnt_q == 6'd1) ? StIdle : StShFetch;
                        end
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            StShReply: begin
                if (!TX_FULL) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = resp_q;
                    state_d   = (cnt_q == 6'd0) ? StIdle : StShFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign RX_RD_REQ = rx_rd_q;
    assign TX_WR_REQ = tx_wr_q;
    assign TX_DATA   = tx_data_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;
    assign NCE       = nce_q;
    assign NCS       = ncs_q;
    assign LED       = led_q;

endmodule

// File: tb/tb_usb_blaster_cmd_engine.sv
// Directed bench for usb_blaster_cmd_engine with a simple RX FIFO model and pin monitors.
module tb_usb_blaster_cmd_engine;

    localparam int unsigned TCK_HALF = 2;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       TX_FULL;
    logic       ASDO;
    logic       tdo_val;
    logic       loop_en;
    logic [7:0] RX_DATA = 8'h00;
    logic       RX_EMPTY, RX_RD_REQ, TX_WR_REQ, TDO;
    logic       TCK, TMS, TDI, NCE, NCS, LED;
    logic [7:0] TX_DATA;

    logic [7:0] rx_mem [64];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    int errors = 0;
    int checks = 0;

    // monitor state
    int         rd_pulses = 0;
    int         tx_cnt = 0;
    int         proto_err = 0;
    int         rises = 0;
    int         good_hi = 0;
    int         bad_hi = 0;
    int         hi_len = 0;
    int         pin_changes = 0;
    logic       tck_prev = 1'b0;
    logic [5:0] pins_prev = 6'b0;
    logic [7:0] tx_mem [64];
    logic       tdi_log [256];

    assign RX_EMPTY = (rd_ptr == wr_ptr);
    assign TDO      = loop_en ? TDI : tdo_val;

    always #5 CLK = ~CLK;

    usb_blaster_cmd_engine #(.TCK_HALF(TCK_HALF)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .RX_EMPTY (RX_EMPTY),
        .RX_RD_REQ(RX_RD_REQ),
        .RX_DATA  (RX_DATA),
        .TX_FULL  (TX_FULL),
        .TX_WR_REQ(TX_WR_REQ),
        .TX_DATA  (TX_DATA),
        .TCK      (TCK),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO),
        .NCE      (NCE),
        .NCS      (NCS),
        .ASDO     (ASDO),
        .LED      (LED)
    );

    // RX FIFO: data appears in the cycle after a read strobe.
    always @(posedge CLK) begin
        if (RX_RD_REQ) begin
            RX_DATA <= rx_mem[rd_ptr % 64];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Mid-cycle monitor of strobes and pins.
    always @(negedge CLK) begin
        if (RX_RD_REQ) begin
            rd_pulses++;
            if (RX_EMPTY) proto_err++;
        end
        if (TX_WR_REQ) begin
            tx_mem[tx_cnt % 64] = TX_DATA;
            tx_cnt++;
            if (TX_FULL) proto_err++;
        end
        if (RX_RD_REQ && TX_WR_REQ) proto_err++;
        if (TCK && !tck_prev) begin
            tdi_log[rises % 256] = TDI;
            rises++;
        end
        if (TCK) begin
            hi_len++;
        end else if (hi_len != 0) begin
            if (hi_len == TCK_HALF) good_hi++;
            else bad_hi++;
            hi_len = 0;
        end
        if ({TCK, TMS, TDI, NCE, NCS, LED} != pins_prev) pin_changes++;
        pins_prev = {TCK, TMS, TDI, NCE, NCS, LED};
        tck_prev  = TCK;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[wr_ptr % 64] = b;
        wr_ptr++;
    endtask

    task automatic wait_tx(input int target, input int budget, input string name);
        int n = 0;
        while (tx_cnt < target && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (tx_cnt < target) begin
            errors++;
            $display("FAIL %s: tx writes=%0d required=%0d (timeout)", name, tx_cnt, target);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; TX_FULL = 1'b0; ASDO = 1'b0; tdo_val = 1'b0; loop_en = 1'b0;
        tick(3);
        checks++;
        if ({TCK, TMS, TDI, NCE, NCS, LED, RX_RD_REQ, TX_WR_REQ} !== 8'b0001_1000) begin
            errors++;
            $display("FAIL reset_pins: got %b want 00011000",
                     {TCK, TMS, TDI, NCE, NCS, LED, RX_RD_REQ, TX_WR_REQ});
        end
        checks++;
        if (TX_DATA !== 8'h00) begin
            errors++; $display("FAIL reset_txdata: got %h want 00", TX_DATA);
        end
        nRST = 1'b1;
        tick(2);
    endtask

    task automatic test_bb_write();
        int rd0 = rd_pulses;
        int tx0 = tx_cnt;
        push(8'h13);
        tick(2);
        checks++;
        if ({TCK, TMS, TDI, NCE, NCS, LED} !== 6'b000110) begin
            errors++; $display("FAIL bbw_early: got %b want 000110", {TCK, TMS, TDI, NCE, NCS, LED});
        end
        tick(1);
        checks++;
        if ({TCK, TMS, TDI, NCE, NCS, LED} !== 6'b111000) begin
            errors++; $display("FAIL bbw_pins: got %b want 111000", {TCK, TMS, TDI, NCE, NCS, LED});
        end
        tick(4);
        checks++;
        if (rd_pulses - rd0 !== 1) begin
            errors++; $display("FAIL bbw_rd: got %0d want 1", rd_pulses - rd0);
        end
        checks++;
        if (tx_cnt - tx0 !== 0) begin
            errors++; $display("FAIL bbw_tx: got %0d want 0", tx_cnt - tx0);
        end
    endtask

    task automatic test_bb_read(input logic tdo, input logic asdo, input logic [7:0] exp);
        int tx0 = tx_cnt;
        loop_en = 1'b0; tdo_val = tdo; ASDO = asdo;
        push(8'h40);
        tick(4);
        checks++;
        if (TX_WR_REQ !== 1'b0) begin
            errors++; $display("FAIL bbr_early: got %b want 0", TX_WR_REQ);
        end
        tick(1);
        checks++;
        if (TX_WR_REQ !== 1'b1 || TX_DATA !== exp) begin
            errors++; $display("FAIL bbr_data: got wr=%b data=%h want wr=1 data=%h",
                               TX_WR_REQ, TX_DATA, exp);
        end
        tick(4);
        checks++;
        if (tx_cnt - tx0 !== 1) begin
            errors++; $display("FAIL bbr_count: got %0d want 1", tx_cnt - tx0);
        end
    endtask

    task automatic test_shift_read();
        int tx0 = tx_cnt;
        int r0 = rises;
        int g0 = good_hi;
        int b0 = bad_hi;
        int rd0 = rd_pulses;
        logic [15:0] w;
        loop_en = 1'b1;
        push(8'hC2); push(8'hA5); push(8'h3C);
        wait_tx(tx0 + 2, 300, "shr_wait");
        tick(5);
        for (int k = 0; k < 16; k++) w[k] = tdi_log[(r0 + k) % 256];
        checks++;
        if (tx_mem[tx0 % 64] !== 8'hA5 || tx_mem[(tx0 + 1) % 64] !== 8'h3C) begin
            errors++; $display("FAIL shr_tx: got %h %h want a5 3c",
                               tx_mem[tx0 % 64], tx_mem[(tx0 + 1) % 64]);
        end
        checks++;
        if (rises - r0 !== 16) begin
            errors++; $display("FAIL shr_rises: got %0d want 16", rises - r0);
        end
        checks++;
        if (good_hi - g0 !== 16 || bad_hi - b0 !== 0) begin
            errors++; $display("FAIL shr_high_len: got good=%0d bad=%0d want good=16 bad=0",
                               good_hi - g0, bad_hi - b0);
        end
        checks++;
        if (w !== 16'h3CA5) begin
            errors++; $display("FAIL shr_tdi: got %h want 3ca5", w);
        end
        checks++;
        if (rd_pulses - rd0 !== 3 || tx_cnt - tx0 !== 2 || TCK !== 1'b0) begin
            errors++; $display("FAIL shr_end: got rd=%0d tx=%0d tck=%b want rd=3 tx=2 tck=0",
                               rd_pulses - rd0, tx_cnt - tx0, TCK);
        end
    endtask

    task automatic test_shift_noread();
        int tx0 = tx_cnt;
        int r0 = rises;
        logic [7:0] w;
        loop_en = 1'b0; tdo_val = 1'b0;
        push(8'h81); push(8'hFF);
        tick(60);
        for (int k = 0; k < 8; k++) w[k] = tdi_log[(r0 + k) % 256];
        checks++;
        if (rises - r0 !== 8 || w !== 8'hFF) begin
            errors++; $display("FAIL shn_pulses: got rises=%0d tdi=%h want rises=8 tdi=ff",
                               rises - r0, w);
        end
        checks++;
        if (tx_cnt - tx0 !== 0 || TCK !== 1'b0) begin
            errors++; $display("FAIL shn_tx: got tx=%0d tck=%b want tx=0 tck=0", tx_cnt - tx0, TCK);
        end
        // 0x80 no-op followed directly by a read: the read reply lands 3 + 5 cycles later
        r0 = rises;
        tdo_val = 1'b1; ASDO = 1'b0;
        push(8'h80); push(8'h40);
        tick(7);
        checks++;
        if (TX_WR_REQ !== 1'b0) begin
            errors++; $display("FAIL noop_early: got %b want 0", TX_WR_REQ);
        end
        tick(1);
        checks++;
        if (TX_WR_REQ !== 1'b1 || TX_DATA !== 8'h01) begin
            errors++; $display("FAIL noop_follow: got wr=%b data=%h want wr=1 data=01",
                               TX_WR_REQ, TX_DATA);
        end
        tick(3);
        checks++;
        if (rises - r0 !== 0 || tx_cnt - tx0 !== 1) begin
            errors++; $display("FAIL noop_quiet: got rises=%0d tx=%0d want rises=0 tx=1",
                               rises - r0, tx_cnt - tx0);
        end
    endtask

    task automatic test_backpressure();
        int tx0 = tx_cnt;
        int pc0;
        loop_en = 1'b0; tdo_val = 1'b0; ASDO = 1'b1; TX_FULL = 1'b1;
        push(8'h7E);
        tick(4);
        pc0 = pin_changes;
        tick(10);
        checks++;
        if (pin_changes - pc0 !== 0 || {TCK, TMS, TDI, NCE, NCS, LED} !== 6'b011111) begin
            errors++; $display("FAIL bp_pins: got changes=%0d pins=%b want changes=0 pins=011111",
                               pin_changes - pc0, {TCK, TMS, TDI, NCE, NCS, LED});
        end
        checks++;
        if (tx_cnt - tx0 !== 0) begin
            errors++; $display("FAIL bp_nowrite: got %0d want 0", tx_cnt - tx0);
        end
        TX_FULL = 1'b0;
        wait_tx(tx0 + 1, 20, "bp_wait");
        tick(3);
        checks++;
        if (tx_cnt - tx0 !== 1 || tx_mem[tx0 % 64] !== 8'h02) begin
            errors++; $display("FAIL bp_release: got tx=%0d data=%h want tx=1 data=02",
                               tx_cnt - tx0, tx_mem[tx0 % 64]);
        end
    endtask

    task automatic test_underrun();
        int tx0 = tx_cnt;
        loop_en = 1'b1;
        push(8'hC2); push(8'h55);
        tick(60);
        checks++;
        if (TCK !== 1'b0 || RX_RD_REQ !== 1'b0 || tx_cnt - tx0 !== 1) begin
            errors++; $display("FAIL ur_stall: got tck=%b rd=%b tx=%0d want tck=0 rd=0 tx=1",
                               TCK, RX_RD_REQ, tx_cnt - tx0);
        end
        checks++;
        if (tx_mem[tx0 % 64] !== 8'h55) begin
            errors++; $display("FAIL ur_first: got %h want 55", tx_mem[tx0 % 64]);
        end
        push(8'hAA);
        wait_tx(tx0 + 2, 100, "ur_wait");
        tick(5);
        checks++;
        if (tx_mem[(tx0 + 1) % 64] !== 8'hAA) begin
            errors++; $display("FAIL ur_second: got %h want aa", tx_mem[(tx0 + 1) % 64]);
        end
    endtask

    task automatic test_reset_mid_shift();
        int tx0 = tx_cnt;
        int r0 = rises;
        int rd0;
        int n = 0;
        loop_en = 1'b1;
        push(8'hC1); push(8'h0F);
        while (rises - r0 < 3 && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (rises - r0 < 3) begin
            errors++; $display("FAIL rst_wait: got rises=%0d want 3 (timeout)", rises - r0);
        end
        tick(2);  // now in the low phase of the 4th bit
        nRST = 1'b0;
        tick(1);
        checks++;
        if ({TCK, TMS, TDI, NCE, NCS, LED, RX_RD_REQ, TX_WR_REQ} !== 8'b0001_1000
            || TX_DATA !== 8'h00) begin
            errors++; $display("FAIL rst_mid: got pins=%b data=%h want 00011000 data=00",
                               {TCK, TMS, TDI, NCE, NCS, LED, RX_RD_REQ, TX_WR_REQ}, TX_DATA);
        end
        nRST = 1'b1;
        tick(20);
        checks++;
        if (rises - r0 !== 3 || tx_cnt - tx0 !== 0) begin
            errors++; $display("FAIL rst_abandon: got rises=%0d tx=%0d want rises=3 tx=0",
                               rises - r0, tx_cnt - tx0);
        end
        rd0 = rd_pulses;
        push(8'h13);
        tick(3);
        checks++;
        if ({TCK, TMS, TDI, NCE, NCS, LED} !== 6'b111000) begin
            errors++; $display("FAIL rst_next: got %b want 111000", {TCK, TMS, TDI, NCE, NCS, LED});
        end
        tick(3);
        checks++;
        if (rd_pulses - rd0 !== 1 || tx_cnt - tx0 !== 0) begin
            errors++; $display("FAIL rst_next_cnt: got rd=%0d tx=%0d want rd=1 tx=0",
                               rd_pulses - rd0, tx_cnt - tx0);
        end
    endtask

    initial begin
        test_reset();
        test_bb_write();
        test_bb_read(1'b1, 1'b0, 8'h01);
        test_bb_read(1'b0, 1'b1, 8'h02);
        test_shift_read();
        test_shift_noread();
        test_backpressure();
        test_underrun();
        test_reset_mid_shift();
        checks++;
        if (proto_err !== 0) begin
            errors++; $display("FAIL protocol: got %0d strobe violations want 0", proto_err);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
